dmem_write_buffer: RTL and testbench

//  Posted-write buffer between cpu data port and datamem. CPU stores enqueue in zero wait

---
 rtl/dmem_pkg.sv | 19 +
 rtl/wb_fwd_match.sv | 36 +++
 rtl/dmem_write_buffer.sv | 117 +++++++++++
 tb/tb_dmem_write_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory posted-write buffer.
package dmem_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 32;
    localparam int WB_DW    = 32;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_READ,
        BUS_DRAIN
    } bus_state_e;

endpackage

// File: rtl/wb_fwd_match.sv
// Combinational store-to-load forwarding search: finds the youngest queued
// entry whose word address matches the lookup address.
module wb_fwd_match
    import dmem_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wb_entry_t       i_q [DEPTH],
    input  logic [PW-1:0]   i_head,
    input  logic [CW-1:0]   i_count,
    input  logic            i_en,
    input  logic [AW-1:0]   i_addr,
    output logic            o_hit,
    output logic [DW-1:0]   o_data
);

    // Walk oldest to youngest so the last match found wins.
    always_comb begin
        logic [PW-1:0] w_idx;
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PW'(i);
            if (i_en && (CW'(i) < i_count) && (i_q[w_idx].addr[AW-1:2] == i_addr[AW-1:2])) begin
                o_hit  = 1'b1;
                o_data = i_q[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the CPU data port and datamem: stores queue with
// zero wait states, drain on bus cycles free of loads, loads forward from queue.
module dmem_write_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_memwrite,
    input  logic          cpu_memread,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_writedata,
    output logic [DW-1:0] cpu_readdata,
    output logic          stall,
    output logic          empty,
    output logic          memwrite,
    output logic          memread,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_writedata,
    input  logic [DW-1:0] mem_readdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t     r_q [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_enq;
    logic          w_deq;
    logic          w_hit;
    logic [DW-1:0] w_fwd_data;
    bus_state_e    w_bus;

    assign w_full = (r_count == CW'(DEPTH));
    assign stall  = cpu_memwrite && w_full;
    assign w_enq  = cpu_memwrite && !w_full;
    assign w_deq  = (w_bus == BUS_DRAIN);
    assign empty  = (r_count == '0);

    // Loads own the bus; queued writes only drain on cycles without a load.
    always_comb begin
        if (cpu_memread)
            w_bus = BUS_READ;
        else if (r_count != '0)
            w_bus = BUS_DRAIN;
        else
            w_bus = BUS_IDLE;
    end

    always_comb begin
        memread       = 1'b0;
        memwrite      = 1'b0;
        mem_addr      = '0;
        mem_writedata = '0;
        case (w_bus)
            BUS_READ: begin
                memread  = 1'b1;
                mem_addr = cpu_addr;
            end
            BUS_DRAIN: begin
                memwrite      = 1'b1;
                mem_addr      = r_q[r_head].addr;
                mem_writedata = r_q[r_head].data;
            end
            default: ;
        endcase
    end

    // Entry storage holds data only; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (w_enq)
            r_q[r_tail] <= '{addr: cpu_addr, data: cpu_writedata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + 1'b1;
            if (w_deq)
                r_head <= r_head + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Forwarding sees only entries present before this cycle's store.
    wb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .i_q     (r_q),
        .i_head  (r_head),
        .i_count (r_count),
        .i_en    (cpu_memread),
        .i_addr  (cpu_addr),
        .o_hit   (w_hit),
        .o_data  (w_fwd_data)
    );

    assign cpu_readdata = w_hit ? w_fwd_data : mem_readdata;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer with a small datamem model and write log.
module tb_dmem_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        stall;
    logic        empty;
    logic        memwrite;
    logic        memread;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int n_vec = 0;
    int n_mis = 0;

    logic [31:0] dmem [0:63] = '{12: 32'h5A5A, default: 32'h0};
    logic [31:0] log_a [0:31];
    logic [31:0] log_d [0:31];
    int          log_n = 0;
    int          base;

    always #5 clk = ~clk;

    dmem_write_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_memread   (cpu_memread),
        .cpu_addr      (cpu_addr),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .stall         (stall),
        .empty         (empty),
        .memwrite      (memwrite),
        .memread       (memread),
        .mem_addr      (mem_addr),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    assign mem_readdata = dmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (memwrite) begin
            dmem[mem_addr[7:2]] <= mem_writedata;
            log_a[log_n] <= mem_addr;
            log_d[log_n] <= mem_writedata;
            log_n <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_memwrite  = we;
        cpu_memread   = re;
        cpu_addr      = a;
        cpu_writedata = d;
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (empty) break;
            drive(1'b0, 1'b0, 32'h0, 32'h0);
        end
        chk(tag, empty, 1'b1);
    endtask

    task automatic chk_log(input string tag, input int n, input logic [31:0] ea [8], input logic [31:0] ed [8]);
        chk({tag, "_nwr"}, log_n - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < log_n) begin
                chk($sformatf("%s_a%0d", tag, i), log_a[base + i], ea[i]);
                chk($sformatf("%s_d%0d", tag, i), log_d[base + i], ed[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ea [8];
        logic [31:0] ed [8];
        reset = 1'b1;
        cpu_memwrite = 1'b0; cpu_memread = 1'b0; cpu_addr = '0; cpu_writedata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_stall", stall, 1'b0);
        chk("rst_memwrite", memwrite, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: reset with three queued entries loses them
        base = log_n;
        drive(1'b1, 1'b1, 32'h40, 32'hC0);
        drive(1'b1, 1'b1, 32'h44, 32'hC1);
        drive(1'b1, 1'b1, 32'h48, 32'hC2);
        drive(1'b0, 1'b1, 32'h100, 32'h0);
        chk("t1_not_empty", empty, 1'b0);
        chk("t1_no_wr_load", memwrite, 1'b0);
        @(negedge clk);
        cpu_memwrite = 1'b0; cpu_memread = 1'b0; cpu_addr = '0;
        reset = 1'b1;
        #1;
        chk("t1_rst_empty", empty, 1'b1);
        chk("t1_rst_memwrite", memwrite, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            chk($sformatf("t1_idle_wr%0d", i), memwrite, 1'b0);
        end
        chk("t1_nwr", log_n - base, 0);

        // Test 2: single store drains on next idle cycle
        base = log_n;
        drive(1'b1, 1'b0, 32'h10, 32'hAA);
        chk("t2_stall", stall, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t2_memwrite", memwrite, 1'b1);
        chk("t2_addr", mem_addr, 32'h10);
        chk("t2_data", mem_writedata, 32'hAA);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t2_empty", empty, 1'b1);

        // Test 3: youngest-match forwarding, same-cycle store not visible
        base = log_n;
        drive(1'b1, 1'b1, 32'h20, 32'h11);
        chk("t3_rd_nostore", cpu_readdata, 32'h0);
        drive(1'b1, 1'b1, 32'h20, 32'h22);
        chk("t3_rd_old", cpu_readdata, 32'h11);
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        chk("t3_rd_young", cpu_readdata, 32'h22);
        chk("t3_memread", memread, 1'b1);
        chk("t3_memwrite", memwrite, 1'b0);
        drain("t3_drain");
        ea[0] = 32'h20; ed[0] = 32'h11;
        ea[1] = 32'h20; ed[1] = 32'h22;
        chk_log("t3", 2, ea, ed);

        // Test 4: full queue starved by loads, then a stalled store
        base = log_n;
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 32'h50 + 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 32'h100, 32'h0);
            chk($sformatf("t4_starve_wr%0d", i), memwrite, 1'b0);
        end
        chk("t4_full_not_empty", empty, 1'b0);
        drive(1'b1, 1'b0, 32'h60, 32'h5);
        chk("t4_stall", stall, 1'b1);
        chk("t4_drain_wr", memwrite, 1'b1);
        chk("t4_drain_addr", mem_addr, 32'h50);
        drive(1'b1, 1'b0, 32'h60, 32'h5);
        chk("t4_accept", stall, 1'b0);
        drain("t4_drain");
        for (int i = 0; i < 5; i++) begin
            ea[i] = 32'h50 + 32'(4 * i);
            ed[i] = 32'(i + 1);
        end
        chk_log("t4", 5, ea, ed);

        // Test 5: back-to-back stores never stall
        base = log_n;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h80 + 32'(4 * i), 32'h100 + 32'(i));
            chk($sformatf("t5_stall%0d", i), stall, 1'b0);
        end
        drain("t5_drain");
        for (int i = 0; i < 5; i++) begin
            ea[i] = 32'h80 + 32'(4 * i);
            ed[i] = 32'h100 + 32'(i);
        end
        chk_log("t5", 5, ea, ed);

        // Test 6: load miss reads datamem directly
        drive(1'b0, 1'b1, 32'h30, 32'h0);
        chk("t6_rd", cpu_readdata, 32'h5A5A);
        chk("t6_memread", memread, 1'b1);
        chk("t6_addr", mem_addr, 32'h30);
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
